// File: rtl/rom_dl_pkg.sv
// Shared constants and types for the ROM download sequencer.
package rom_dl_pkg;

  localparam logic [17:0] ADDR_CPU     = 18'h00000;
  localparam logic [17:0] ADDR_SP      = 18'h10000;
  localparam logic [17:0] ADDR_BG      = 18'h20000;
  localparam logic [17:0] ADDR_SPCLUT  = 18'h28000;
  localparam logic [17:0] ADDR_BGCLUT  = 18'h28100;
  localparam logic [17:0] ADDR_PALET   = 18'h28200;
  localparam logic [17:0] ADDR_ROM_END = 18'h28240;

  typedef enum logic [1:0] {StIdle, StLoad, StDrain, StDone} state_e;

  typedef struct packed {
    logic [17:0] ad;
    logic [7:0]  dt;
  } dl_entry_t;

endpackage

// File: rtl/rom_dl_sequencer_if.sv
// Host download port and ROM write bus of the download sequencer.
interface rom_dl_sequencer_if;
  logic        IO_DL;
  logic        IO_WR;
  logic [24:0] IO_AD;
  logic [7:0]  IO_DT;
  logic        IO_WAIT;
  logic [17:0] DLAD;
  logic [7:0]  DLDT;
  logic        DLEN;
  logic        CPU_HOLD;
  logic        DONE;
  logic [1:0]  ERR;

  modport master (
    output IO_DL, IO_WR, IO_AD, IO_DT,
    input  IO_WAIT, DLAD, DLDT, DLEN, CPU_HOLD, DONE, ERR
  );

  modport slave (
    input  IO_DL, IO_WR, IO_AD, IO_DT,
    output IO_WAIT, DLAD, DLDT, DLEN, CPU_HOLD, DONE, ERR
  );
endinterface

// File: rtl/rom_dl_fifo.sv
// Synchronous first-word-fall-through FIFO of download entries.
module rom_dl_fifo
  import rom_dl_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     CL,
  input  logic                     RST_N,
  input  logic                     i_push,
  input  dl_entry_t                i_data,
  input  logic                     i_pop,
  output dl_entry_t                o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int unsigned PW = $clog2(DEPTH);

  dl_entry_t     r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;

  always_ff @(posedge CL) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge CL) begin
    if (!RST_N) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (PW+1)'(DEPTH));
  assign o_count = r_count;
endmodule

// File: rtl/rom_dl_sequencer.sv
// Queues host download bytes and replays them as gapped ROM-bus writes; holds CPUs until done.
module rom_dl_sequencer
  import rom_dl_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned GAP     = 1,
  parameter logic [17:0] ROM_END = ADDR_ROM_END
) (
  input logic               CL,
  input logic               RST_N,
  rom_dl_sequencer_if.slave bus
);
  localparam int unsigned   PW       = $clog2(DEPTH);
  localparam int unsigned   GW       = (GAP > 1) ? $clog2(GAP + 1) : 1;
  localparam logic [GW-1:0] GAP_LD   = GW'(GAP);
  localparam logic [PW:0]   WAIT_LVL = (PW+1)'(DEPTH - 1);

  state_e        r_state;
  logic          r_dl;
  logic [GW-1:0] r_gap;
  logic          r_dlen;
  logic          r_wait;
  logic          r_hold;
  logic          r_done;
  logic [17:0]   r_dlad;
  logic [7:0]    r_dldt;
  logic [1:0]    r_err;

  logic          w_loading;
  logic          w_active;
  logic          w_rise;
  logic          w_fall;
  logic          w_in_range;
  logic          w_gap_zero;
  logic          w_wr;
  logic          w_push;
  logic          w_pop;
  logic          w_oor;
  logic          w_ovf;
  logic          w_full;
  logic          w_empty;
  logic [PW:0]   w_count;
  dl_entry_t     w_wdata;
  dl_entry_t     w_rdata;

  assign w_loading  = (r_state == StLoad);
  assign w_active   = w_loading || (r_state == StDrain);
  assign w_rise     = bus.IO_DL & ~r_dl;
  assign w_fall     = ~bus.IO_DL & r_dl;
  assign w_in_range = (bus.IO_AD < {7'd0, ROM_END});
  assign w_gap_zero = (r_gap == '0);
  assign w_pop      = w_active && !w_empty && w_gap_zero;
  assign w_wr       = w_loading && bus.IO_WR;
  // A full FIFO still takes the byte when an entry leaves in the same cycle.
  assign w_push     = w_wr && w_in_range && (!w_full || w_pop);
  assign w_oor      = w_wr && !w_in_range;
  assign w_ovf      = w_wr && w_in_range && w_full && !w_pop;
  assign w_wdata    = '{ad: bus.IO_AD[17:0], dt: bus.IO_DT};

  rom_dl_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .CL      (CL),
    .RST_N   (RST_N),
    .i_push  (w_push),
    .i_data  (w_wdata),
    .i_pop   (w_pop),
    .o_data  (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge CL) begin
    if (!RST_N) begin
      r_state <= StIdle;
      // Track IO_DL through reset so a window held open across reset is not seen as a new rise.
      r_dl    <= bus.IO_DL;
      r_gap   <= '0;
      r_dlen  <= 1'b0;
      r_dlad  <= '0;
      r_dldt  <= '0;
      r_wait  <= 1'b0;
      r_hold  <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= '0;
    end else begin
      r_dl   <= bus.IO_DL;
      r_dlen <= w_pop;
      r_wait <= (w_count >= WAIT_LVL);
      r_err  <= r_err | {w_ovf, w_oor};
      if (w_pop) begin
        r_dlad <= w_rdata.ad;
        r_dldt <= w_rdata.dt;
        r_gap  <= GAP_LD;
      end else if (!w_gap_zero) begin
        r_gap  <= r_gap - GW'(1);
      end
      unique case (r_state)
        StIdle: begin
          if (w_rise) r_state <= StLoad;
        end
        StLoad: begin
          if (w_fall) r_state <= StDrain;
        end
        StDrain: begin
          if (w_empty && w_gap_zero) begin
            r_state <= StDone;
            r_hold  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        StDone: begin
          if (w_rise) begin
            r_state <= StLoad;
            r_hold  <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= '0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.IO_WAIT  = r_wait;
  assign bus.DLAD     = r_dlad;
  assign bus.DLDT     = r_dldt;
  assign bus.DLEN     = r_dlen;
  assign bus.CPU_HOLD = r_hold;
  assign bus.DONE     = r_done;
  assign bus.ERR      = r_err;
endmodule

// File: tb/tb_rom_dl_sequencer.sv
// Self-checking bench for rom_dl_sequencer: directed corner cases, an address table, random runs.
module tb_rom_dl_sequencer;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned GAP     = 1;
  localparam logic [24:0] ROM_END = 25'h0028240;

  logic CL = 1'b0;
  logic RST_N = 1'b0;

  rom_dl_sequencer_if bus ();

  rom_dl_sequencer #(
    .DEPTH   (DEPTH),
    .GAP     (GAP),
    .ROM_END (18'h28240)
  ) dut (
    .CL    (CL),
    .RST_N (RST_N),
    .bus   (bus)
  );

  always #5 CL = ~CL;

  int cyc = 0;
  always @(posedge CL) cyc <= cyc + 1;

  logic [25:0] got_q[$];
  int          got_cyc[$];
  always @(negedge CL) begin
    if (bus.DLEN) begin
      got_q.push_back({bus.DLAD, bus.DLDT});
      got_cyc.push_back(cyc);
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [25:0] got_at(input int i);
    return (i < got_q.size()) ? got_q[i] : '1;
  endfunction

  function automatic int cyc_at(input int i);
    return (i < got_cyc.size()) ? got_cyc[i] : -1000;
  endfunction

  task automatic tick();
    @(posedge CL);
    #1;
  endtask

  task automatic clear_got();
    got_q.delete();
    got_cyc.delete();
  endtask

  task automatic wr(input logic [24:0] ad, input logic [7:0] dt);
    bus.IO_WR = 1'b1;
    bus.IO_AD = ad;
    bus.IO_DT = dt;
    tick();
    bus.IO_WR = 1'b0;
  endtask

  task automatic dl_start();
    bus.IO_DL = 1'b1;
    tick();
  endtask

  task automatic dl_end();
    bus.IO_DL = 1'b0;
    tick();
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!bus.DONE && n < 200) begin
      tick();
      n++;
    end
    chk(name, {31'd0, bus.DONE}, 32'd1);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_dlen"}, {31'd0, bus.DLEN}, 32'd0);
    chk({tag, "_dlad"}, {14'd0, bus.DLAD}, 32'd0);
    chk({tag, "_dldt"}, {24'd0, bus.DLDT}, 32'd0);
    chk({tag, "_wait"}, {31'd0, bus.IO_WAIT}, 32'd0);
    chk({tag, "_hold"}, {31'd0, bus.CPU_HOLD}, 32'd1);
    chk({tag, "_done"}, {31'd0, bus.DONE}, 32'd0);
    chk({tag, "_err"}, {30'd0, bus.ERR}, 32'd0);
  endtask

  typedef struct {
    logic [24:0] ad;
    logic [7:0]  dt;
    logic        emit;
  } vec_t;

  vec_t        vecs[8];
  logic [25:0] exp_q[$];
  int          wcyc[$];
  logic [24:0] ad;
  logic [7:0]  dt;
  logic        oor;
  logic        ok;
  logic        saw_wait;
  logic        prev_hold;
  int          w0;
  int          guard;
  int          done_cyc;

  initial begin
    vecs[0] = '{ad: 25'h0000000, dt: 8'h11, emit: 1'b1};
    vecs[1] = '{ad: 25'h0010000, dt: 8'h22, emit: 1'b1};
    vecs[2] = '{ad: 25'h0028240, dt: 8'h33, emit: 1'b0};
    vecs[3] = '{ad: 25'h1000000, dt: 8'h44, emit: 1'b0};
    vecs[4] = '{ad: 25'h002823F, dt: 8'h55, emit: 1'b1};
    vecs[5] = '{ad: 25'h0028100, dt: 8'h66, emit: 1'b1};
    vecs[6] = '{ad: 25'h0040000, dt: 8'h77, emit: 1'b0};
    vecs[7] = '{ad: 25'h0020000, dt: 8'h88, emit: 1'b1};

    bus.IO_DL = 1'b0;
    bus.IO_WR = 1'b0;
    bus.IO_AD = '0;
    bus.IO_DT = '0;
    RST_N = 1'b0;
    tick();
    tick();
    RST_N = 1'b1;
    tick();
    chk_reset_outs("rst");

    // Three single writes: 2-cycle latency, GAP+1 spacing.
    dl_start();
    clear_got();
    wr(25'd0, 8'hA5);
    w0 = cyc;
    wr(25'd1, 8'h5A);
    wr(25'd2, 8'hC3);
    repeat (8) tick();
    chk("t1_count", got_q.size(), 3);
    chk("t1_b0", got_at(0), {18'd0, 8'hA5});
    chk("t1_b1", got_at(1), {18'd1, 8'h5A});
    chk("t1_b2", got_at(2), {18'd2, 8'hC3});
    chk("t1_lat", cyc_at(0), w0 + 1);
    chk("t1_gap01", cyc_at(1) - cyc_at(0), GAP + 1);
    chk("t1_gap12", cyc_at(2) - cyc_at(1), GAP + 1);
    chk("t1_hold", {31'd0, bus.CPU_HOLD}, 32'd1);
    dl_end();
    wait_done("t1_done");
    chk("t1_hold_rel", {31'd0, bus.CPU_HOLD}, 32'd0);

    // Burst of 8 from a host that obeys IO_WAIT.
    dl_start();
    chk("t2_hold", {31'd0, bus.CPU_HOLD}, 32'd1);
    chk("t2_done", {31'd0, bus.DONE}, 32'd0);
    clear_got();
    saw_wait = 1'b0;
    for (int i = 0; i < 8; i++) begin
      guard = 0;
      while (bus.IO_WAIT && guard < 64) begin
        saw_wait = 1'b1;
        tick();
        guard++;
      end
      wr(25'h200 + 25'(i), 8'h80 + 8'(i));
    end
    dl_end();
    wait_done("t2_done_end");
    chk("t2_wait_seen", {31'd0, saw_wait}, 32'd1);
    chk("t2_count", got_q.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t2_b%0d", i), got_at(i), {18'h200 + 18'(i), 8'h80 + 8'(i)});
    end
    chk("t2_err", {30'd0, bus.ERR}, 32'd0);

    // Ten back-to-back writes ignoring IO_WAIT: only the ninth finds the FIFO full with no pop.
    dl_start();
    clear_got();
    for (int i = 0; i < 10; i++) wr(25'h100 + 25'(i), 8'h30 + 8'(i));
    dl_end();
    wait_done("t3_done");
    chk("t3_count", got_q.size(), 9);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("t3_b%0d", i), got_at(i),
          {18'h100 + 18'((i < 8) ? i : 9), 8'h30 + 8'((i < 8) ? i : 9)});
    end
    chk("t3_err", {30'd0, bus.ERR}, 32'd2);

    // Address table: range check and truncation.
    dl_start();
    chk("t4_err_clr", {30'd0, bus.ERR}, 32'd0);
    oor = 1'b0;
    for (int i = 0; i < 8; i++) begin
      clear_got();
      wr(vecs[i].ad, vecs[i].dt);
      repeat (4) tick();
      if (!vecs[i].emit) oor = 1'b1;
      chk($sformatf("t4_n%0d", i), got_q.size(), {31'd0, vecs[i].emit});
      if (vecs[i].emit) chk($sformatf("t4_v%0d", i), got_at(0), {vecs[i].ad[17:0], vecs[i].dt});
      chk($sformatf("t4_e%0d", i), {30'd0, bus.ERR}, {30'd0, 1'b0, oor});
    end
    dl_end();
    wait_done("t4_done");

    // Write in the IO_DL falling cycle; DONE timing; next rise clears ERR.
    dl_start();
    wr(25'h1FFFFFF, 8'h00);
    repeat (3) tick();
    clear_got();
    bus.IO_DL = 1'b0;
    wr(25'h2823F, 8'h9C);
    done_cyc = -1;
    prev_hold = bus.CPU_HOLD;
    for (int i = 0; i < 20 && done_cyc < 0; i++) begin
      prev_hold = bus.CPU_HOLD;
      tick();
      if (bus.DONE) done_cyc = cyc;
    end
    chk("t5_count", got_q.size(), 1);
    chk("t5_b0", got_at(0), {18'h2823F, 8'h9C});
    chk("t5_done_cyc", done_cyc - cyc_at(0), GAP + 1);
    chk("t5_hold_before", {31'd0, prev_hold}, 32'd1);
    chk("t5_hold_rel", {31'd0, bus.CPU_HOLD}, 32'd0);
    chk("t5_err_kept", {30'd0, bus.ERR}, 32'd1);
    dl_start();
    chk("t5_hold_again", {31'd0, bus.CPU_HOLD}, 32'd1);
    chk("t5_done_clr", {31'd0, bus.DONE}, 32'd0);
    chk("t5_err_clr", {30'd0, bus.ERR}, 32'd0);

    // Reset with entries queued abandons the download until a fresh IO_DL rise.
    for (int i = 0; i < 5; i++) wr(25'h300 + 25'(i), 8'hE0 + 8'(i));
    RST_N = 1'b0;
    tick();
    clear_got();
    chk_reset_outs("t6");
    RST_N = 1'b1;
    tick();
    wr(25'h123, 8'h45);
    repeat (8) tick();
    chk("t6_no_dlen", got_q.size(), 0);
    chk("t6_hold", {31'd0, bus.CPU_HOLD}, 32'd1);
    chk("t6_done", {31'd0, bus.DONE}, 32'd0);
    bus.IO_DL = 1'b0;
    tick();
    dl_start();
    wr(25'h124, 8'h46);
    repeat (4) tick();
    chk("t6_recover", got_at(0), {18'h124, 8'h46});
    dl_end();
    wait_done("t6_done_end");

    // Random downloads against an order/error/timing reference.
    for (int r = 0; r < 3; r++) begin
      dl_start();
      clear_got();
      exp_q.delete();
      wcyc.delete();
      oor = 1'b0;
      for (int i = 0; i < 24; i++) begin
        guard = 0;
        while (bus.IO_WAIT && guard < 64) begin
          tick();
          guard++;
        end
        if (guard == 64) chk("rnd_wait_bound", {31'd0, bus.IO_WAIT}, 32'd0);
        dt = 8'($urandom);
        if ($urandom_range(0, 9) < 7) ad = 25'($urandom_range(0, 32'h2823F));
        else ad = 25'($urandom_range(32'h28240, 32'h1FFFFFF));
        wr(ad, dt);
        if (ad < ROM_END) begin
          exp_q.push_back({ad[17:0], dt});
          wcyc.push_back(cyc);
        end else begin
          oor = 1'b1;
        end
        repeat ($urandom_range(0, 2)) tick();
      end
      dl_end();
      wait_done($sformatf("rnd%0d_done", r));
      chk($sformatf("rnd%0d_count", r), got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
        chk($sformatf("rnd%0d_b%0d", r, i), got_at(i), exp_q[i]);
      end
      chk($sformatf("rnd%0d_err", r), {30'd0, bus.ERR}, {30'd0, 1'b0, oor});
      ok = 1'b1;
      for (int i = 1; i < got_cyc.size(); i++) begin
        if (got_cyc[i] - got_cyc[i-1] < int'(GAP + 1)) ok = 1'b0;
      end
      chk($sformatf("rnd%0d_spacing", r), {31'd0, ok}, 32'd1);
      ok = 1'b1;
      for (int i = 0; i < got_cyc.size() && i < wcyc.size(); i++) begin
        if (got_cyc[i] < wcyc[i] + 1) ok = 1'b0;
      end
      chk($sformatf("rnd%0d_latency", r), {31'd0, ok}, 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
